// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module  : serial_adder_pkg
// Brief   : Shared state encoding and default width for the bit-serial adder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  // Default operand width of the serial adder.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states; 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/serial_adder_fa.sv
// ============================================================================
// Module  : full_adder
// Brief   : Single-bit combinational full adder cell used by the serial adder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  // Sum and majority carry of the three input bits.
  always_comb begin
    s  = a ^ b ^ cin;
    co = (a & b) | (a & cin) | (b & cin);
  end

endmodule : full_adder

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module  : serial_adder
// Brief   : Bit-serial WIDTH-bit adder. Captures a, b and cin on an accepted
//           start, adds one bit per clock LSB-first through one full adder and
//           a carry flip-flop, then presents sum/cout/ovf with a done pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic             fa_s;
  logic             fa_co;
  logic             load;
  logic             last_bit;

  // The single adder cell always sees the current LSBs and the running carry.
  full_adder u_fa (
    .a   (sh_a[0]),
    .b   (sh_b[0]),
    .cin (carry),
    .s   (fa_s),
    .co  (fa_co)
  );

  // A start is only honoured when no addition is in flight.
  always_comb begin
    load     = start && ((state == ST_IDLE) || (state == ST_DONE));
    last_bit = (count == LAST_CNT);
  end

  // New sum bit enters at the MSB so the result ends up LSB-aligned after WIDTH shifts.
  always_comb begin
    sum_next            = sum >> 1;
    sum_next[WIDTH-1]   = fa_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE: begin
        state_next = start ? ST_SHIFT : ST_IDLE;
      end
      ST_SHIFT: begin
        state_next = last_bit ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: begin
        state_next = start ? ST_SHIFT : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered status outputs; busy/done follow the next state so
  // they line up with the cycle the FSM is actually in.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a  <= '0;
      sh_b  <= '0;
      sum   <= '0;
      carry <= 1'b0;
      count <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= (state_next == ST_SHIFT);
      done <= (state_next == ST_DONE);
      if (load) begin
        sh_a  <= a;
        sh_b  <= b;
        carry <= cin;
        count <= '0;
        sum   <= '0;
        cout  <= 1'b0;
        ovf   <= 1'b0;
      end else if (state == ST_SHIFT) begin
        sh_a  <= sh_a >> 1;
        sh_b  <= sh_b >> 1;
        sum   <= sum_next;
        carry <= fa_co;
        count <= count + CNT_ONE;
        if (last_bit) begin
          // On the MSB cycle the carry FF still holds the carry into the MSB.
          cout <= fa_co;
          ovf  <= carry ^ fa_co;
        end
      end
    end
  end

endmodule : serial_adder

`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none

module tb_serial_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp8_t;

  typedef struct packed {
    logic sum;
    logic cout;
    logic ovf;
  } exp1_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  logic       start1 = 1'b0;
  logic       a1 = 1'b0;
  logic       b1 = 1'b0;
  logic       cin1 = 1'b0;
  logic       busy1;
  logic       done1;
  logic       sum1;
  logic       cout1;
  logic       ovf1;

  int checks = 0;
  int errors = 0;

  exp8_t sb8[$];
  exp1_t sb1[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  // Reference model: 9-bit sum and sign-based overflow rule.
  function automatic exp8_t model8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    logic [8:0] t;
    exp8_t      e;
    t      = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
    e.sum  = t[7:0];
    e.cout = t[8];
    e.ovf  = (ta[7] == tb[7]) && (t[7] != ta[7]);
    return e;
  endfunction

  // Drive a start at a negedge; returns at the negedge of cycle 1 with inputs scrambled.
  task automatic drive_start(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    a     = ta;
    b     = tb;
    cin   = tc;
    start = 1'b1;
    sb8.push_back(model8(ta, tb, tc));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    cin   = 1'($urandom);
  endtask

  // Advance from cycle 1 until done is seen; bounded at 40 cycles.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, sum, cout, ovf} !== 12'h000) begin
      errors++;
      $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    checks++;
    if ({busy1, done1, sum1, cout1, ovf1} !== 5'b0) begin
      errors++;
      $display("FAIL reset1: got busy=%b done=%b sum=%b cout=%b ovf=%b, want all 0",
               busy1, done1, sum1, cout1, ovf1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [16:0] vec [6];
    exp8_t       e;
    exp8_t       held;
    int          cyc;
    vec[0] = {8'h5A, 8'h3C, 1'b0};
    vec[1] = {8'hFF, 8'h01, 1'b0};
    vec[2] = {8'hFF, 8'hFF, 1'b1};
    vec[3] = {8'h80, 8'h80, 1'b0};
    vec[4] = {8'h7F, 8'h00, 1'b1};
    vec[5] = {8'hC3, 8'h96, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive_start(vec[i][16:9], vec[i][8:1], vec[i][0]);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL basic_busy[%0d]: got busy=%b done=%b, want busy=1 done=0", i, busy, done);
      end
      wait_done(cyc);
      checks++;
      if (cyc != 9 || busy !== 1'b0) begin
        errors++;
        $display("FAIL basic_latency[%0d]: got done at cycle %0d busy=%b, want cycle 9 busy=0", i, cyc, busy);
      end
      e = (sb8.size() > 0) ? sb8.pop_front() : '0;
      checks++;
      if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
        errors++;
        $display("FAIL basic_result[%0d]: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                 i, sum, cout, ovf, e.sum, e.cout, e.ovf);
      end
      held = '{sum: sum, cout: cout, ovf: ovf};
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
        errors++;
        $display("FAIL basic_hold[%0d]: got done=%b sum=%h cout=%b ovf=%b, want done=0 sum=%h cout=%b ovf=%b",
                 i, done, sum, cout, ovf, held.sum, held.cout, held.ovf);
      end
    end
  endtask

  task automatic test_ignore_start;
    exp8_t e;
    int    dones;
    int    done_cyc;
    drive_start(8'h10, 8'h20, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    a     = 8'hAA;
    @(negedge clk);
    start = 1'b0;
    dones    = 0;
    done_cyc = 0;
    for (int c = 5; c <= 20; c++) begin
      if (done) begin
        dones++;
        done_cyc = c;
        if (dones == 1) begin
          e = (sb8.size() > 0) ? sb8.pop_front() : '0;
          checks++;
          if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
            errors++;
            $display("FAIL ignore_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                     sum, cout, ovf, e.sum, e.cout, e.ovf);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (dones != 1 || done_cyc != 9) begin
      errors++;
      $display("FAIL ignore_done: got %0d done pulses (last at cycle %0d), want 1 at cycle 9", dones, done_cyc);
    end
  endtask

  task automatic test_reset_abort;
    exp8_t e;
    int    seen;
    int    cyc;
    drive_start(8'h33, 8'h44, 1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    rst = 1'b0;
    if (sb8.size() > 0) void'(sb8.pop_back());
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d cycles with busy/done after abort, want 0", seen);
    end
    drive_start(8'h81, 8'h81, 1'b0);
    wait_done(cyc);
    e = (sb8.size() > 0) ? sb8.pop_front() : '0;
    checks++;
    if (cyc != 9 || sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
      errors++;
      $display("FAIL abort_restart: got cycle %0d sum=%h cout=%b ovf=%b, want cycle 9 sum=%h cout=%b ovf=%b",
               cyc, sum, cout, ovf, e.sum, e.cout, e.ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    exp8_t e;
    int    cyc;
    drive_start(8'h64, 8'h9B, 1'b1);
    wait_done(cyc);
    e = (sb8.size() > 0) ? sb8.pop_front() : '0;
    checks++;
    if (cyc != 9 || sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
      errors++;
      $display("FAIL b2b_first: got cycle %0d sum=%h cout=%b ovf=%b, want cycle 9 sum=%h cout=%b ovf=%b",
               cyc, sum, cout, ovf, e.sum, e.cout, e.ovf);
    end
    drive_start(8'h7F, 8'h7F, 1'b1);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h00) begin
      errors++;
      $display("FAIL b2b_reload: got busy=%b done=%b sum=%h, want busy=1 done=0 sum=00", busy, done, sum);
    end
    wait_done(cyc);
    e = (sb8.size() > 0) ? sb8.pop_front() : '0;
    checks++;
    if (cyc != 9 || sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
      errors++;
      $display("FAIL b2b_second: got cycle %0d sum=%h cout=%b ovf=%b, want cycle 9 sum=%h cout=%b ovf=%b",
               cyc, sum, cout, ovf, e.sum, e.cout, e.ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_width1;
    exp1_t e;
    int    v;
    for (int i = 0; i < 8; i++) begin
      a1   = 1'((i >> 2) & 1);
      b1   = 1'((i >> 1) & 1);
      cin1 = 1'(i & 1);
      // Signed 1-bit operands are 0 or -1; carry-in adds +1.
      v    = int'(cin1) - int'(a1) - int'(b1);
      e.sum  = 1'((int'(a1) + int'(b1) + int'(cin1)) & 1);
      e.cout = (int'(a1) + int'(b1) + int'(cin1)) >= 2;
      e.ovf  = (v > 0) || (v < -1);
      sb1.push_back(e);
      start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      a1     = 1'($urandom);
      b1     = 1'($urandom);
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL w1_busy[%0d]: got busy=%b done=%b, want busy=1 done=0", i, busy1, done1);
      end
      @(negedge clk);
      e = (sb1.size() > 0) ? sb1.pop_front() : '0;
      checks++;
      if (done1 !== 1'b1 || sum1 !== e.sum || cout1 !== e.cout || ovf1 !== e.ovf) begin
        errors++;
        $display("FAIL w1_result[%0d]: got done=%b sum=%b cout=%b ovf=%b, want done=1 sum=%b cout=%b ovf=%b",
                 i, done1, sum1, cout1, ovf1, e.sum, e.cout, e.ovf);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_adder

`default_nettype wire
